// File: rtl/alu_issue_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : alu_issue_arbiter_if
// Brief  : Bundles the two requester channels, the ALU drive/return signals
//          and the response channel of alu_issue_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
interface alu_issue_arbiter_if #(
  parameter int DATA_W = 64
);
  // Requester 0 (CPU EX stage)
  logic              req0_valid;
  logic              req0_ready;
  logic [5:0]        req0_op;
  logic [1:0]        req0_width;
  logic [0:DATA_W-1] req0_a;
  logic [0:DATA_W-1] req0_b;
  // Requester 1 (NoC vector offload)
  logic              req1_valid;
  logic              req1_ready;
  logic [5:0]        req1_op;
  logic [1:0]        req1_width;
  logic [0:DATA_W-1] req1_a;
  logic [0:DATA_W-1] req1_b;
  // Shared ALU
  logic              alu_en;
  logic [5:0]        alu_op_o;
  logic [1:0]        width_o;
  logic [0:DATA_W-1] reg_a_o;
  logic [0:DATA_W-1] reg_b_o;
  logic [0:DATA_W-1] alu_out_i;
  // Response channel
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [0:DATA_W-1] resp_data;
  logic              resp_err;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_op, req0_width, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_width, req1_a, req1_b,
    output req1_ready,
    output alu_en, alu_op_o, width_o, reg_a_o, reg_b_o,
    input  alu_out_i,
    output resp_valid, resp_id, resp_data, resp_err,
    input  resp_ready
  );

  // Environment side: requesters, ALU and response consumer
  modport master (
    output req0_valid, req0_op, req0_width, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_width, req1_a, req1_b,
    input  req1_ready,
    input  alu_en, alu_op_o, width_o, reg_a_o, reg_b_o,
    output alu_out_i,
    input  resp_valid, resp_id, resp_data, resp_err,
    output resp_ready
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module : alu_issue_arbiter
// Brief  : Round-robin sharing of one combinational vector ALU between the
//          CPU EX stage (port 0) and the NoC offload (port 1). Operands are
//          held on the ALU for an op-dependent number of cycles, then the
//          result is returned with the requester ID over valid/ready.
// Rev    : 1.0 - initial release
// ============================================================================
module alu_issue_arbiter #(
  parameter int DATA_W  = 64,
  parameter int MUL_LAT = 3,
  parameter int ALU_LAT = 1
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  alu_issue_arbiter_if.slave bus
);

  localparam int MAX_LAT = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_rr_ptr;
  logic              r_id;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_alu_en;
  logic [5:0]        r_op;
  logic [1:0]        r_width;
  logic [0:DATA_W-1] r_a;
  logic [0:DATA_W-1] r_b;
  logic              r_resp_valid;
  logic              r_resp_id;
  logic              r_resp_err;
  logic [0:DATA_W-1] r_resp_data;

  logic              w_any;
  logic              w_grant;
  logic              w_accept;
  logic [5:0]        w_op;
  logic [1:0]        w_width;
  logic [0:DATA_W-1] w_a;
  logic [0:DATA_W-1] w_b;

  // Legal opcodes are 1..11 and 13; everything else returns an error.
  function automatic logic f_legal(input logic [5:0] op);
    return ((op >= 6'd1) && (op <= 6'd11)) || (op == 6'd13);
  endfunction

  function automatic logic f_is_mul(input logic [5:0] op);
    return (op == 6'd8) || (op == 6'd9);
  endfunction

  // Combinational grant: a lone requester wins, a tie goes to rr_ptr.
  // reset_n gates acceptance so both readies read 0 while held in reset.
  always_comb begin
    w_any    = bus.req0_valid | bus.req1_valid;
    w_grant  = (bus.req0_valid && bus.req1_valid) ? r_rr_ptr : bus.req1_valid;
    w_accept = reset_n && (r_state == S_IDLE) && w_any;
    w_op     = w_grant ? bus.req1_op    : bus.req0_op;
    w_width  = w_grant ? bus.req1_width : bus.req0_width;
    w_a      = w_grant ? bus.req1_a     : bus.req0_a;
    w_b      = w_grant ? bus.req1_b     : bus.req0_b;
  end

  assign bus.req0_ready = w_accept && !w_grant;
  assign bus.req1_ready = w_accept &&  w_grant;

  // Issue FSM: accept in IDLE, hold operands through EXEC, return in RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= 1'b0;
      r_id         <= 1'b0;
      r_cnt        <= '0;
      r_alu_en     <= 1'b0;
      r_op         <= '0;
      r_width      <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_op     <= w_op;
            r_width  <= w_width;
            r_a      <= w_a;
            r_b      <= w_b;
            r_id     <= w_grant;
            r_rr_ptr <= ~w_grant;
            r_cnt    <= f_is_mul(w_op) ? CNT_W'(MUL_LAT) : CNT_W'(ALU_LAT);
            if (f_legal(w_op)) begin
              r_alu_en <= 1'b1;
              r_state  <= S_EXEC;
            end else begin
              // Illegal ops never touch the ALU and answer immediately.
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_data  <= '0;
              r_resp_id    <= w_grant;
              r_state      <= S_RESP;
            end
          end
        end
        S_EXEC: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_alu_en     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_data  <= bus.alu_out_i;
            r_resp_id    <= r_id;
            r_resp_err   <= 1'b0;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.alu_en     = r_alu_en;
  assign bus.alu_op_o   = r_op;
  assign bus.width_o    = r_width;
  assign bus.reg_a_o    = r_a;
  assign bus.reg_b_o    = r_b;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_issue_arbiter
// Brief  : Self-checking bench for alu_issue_arbiter: vector table, directed
//          multi-cycle sequences and a randomized phase against a
//          transaction-level reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_arbiter;

  localparam int DW      = 64;
  localparam int MUL_LAT = 3;
  localparam int ALU_LAT = 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  alu_issue_arbiter_if #(.DATA_W(DW)) bus();

  alu_issue_arbiter #(
    .DATA_W (DW),
    .MUL_LAT(MUL_LAT),
    .ALU_LAT(ALU_LAT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Stand-in ALU. Its opcode map (2=AND, 3=OR, 6=ADD, 8/9=MUL, else a mix)
  // belongs to the bench only; the arbiter just forwards whatever it returns.
  function automatic logic [0:63] alu_fn(input logic [5:0] op, input logic [1:0] w,
                                         input logic [0:63] a, input logic [0:63] b);
    case (op)
      6'd2:       return a & b;
      6'd3:       return a | b;
      6'd6:       return a + b;
      6'd8, 6'd9: return a * b;
      default:    return a ^ {b[8:63], b[0:7]} ^ {56'd0, w, op};
    endcase
  endfunction

  // Garbage while alu_en is low, so a capture outside EXEC is visible.
  always_comb begin
    bus.alu_out_i = bus.alu_en ? alu_fn(bus.alu_op_o, bus.width_o, bus.reg_a_o, bus.reg_b_o)
                               : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  function automatic bit is_legal(input logic [5:0] op);
    return (op inside {[6'd1:6'd11]}) || (op == 6'd13);
  endfunction

  // Cycles from accept edge to resp_valid high.
  function automatic int lat_of(input logic [5:0] op);
    if (!is_legal(op)) return 0;
    return (op == 6'd8 || op == 6'd9) ? MUL_LAT : ALU_LAT;
  endfunction

  function automatic logic [0:63] exp_of(input logic [5:0] op, input logic [1:0] w,
                                         input logic [0:63] a, input logic [0:63] b);
    return is_legal(op) ? alu_fn(op, w, a, b) : 64'd0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic [5:0] op, input logic [1:0] w,
                       input logic [0:63] a, input logic [0:63] b);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_width = w; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_width = w; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_rdy0"},  bus.req0_ready, 0);
    chk({pfx, "_rdy1"},  bus.req1_ready, 0);
    chk({pfx, "_en"},    bus.alu_en, 0);
    chk({pfx, "_op"},    bus.alu_op_o, 0);
    chk({pfx, "_w"},     bus.width_o, 0);
    chk({pfx, "_a"},     bus.reg_a_o, 0);
    chk({pfx, "_b"},     bus.reg_b_o, 0);
    chk({pfx, "_rv"},    bus.resp_valid, 0);
    chk({pfx, "_id"},    bus.resp_id, 0);
    chk({pfx, "_data"},  bus.resp_data, 0);
    chk({pfx, "_err"},   bus.resp_err, 0);
  endtask

  // Call right after driving at a negedge; returns granted port or -1.
  task automatic wait_grant(output int g);
    int n = 0;
    #1;
    while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    g = bus.req1_ready ? 1 : (bus.req0_ready ? 0 : -1);
    chk("grant_seen", g >= 0, 1);
    chk("one_ready", bus.req0_ready && bus.req1_ready, 0);
  endtask

  task automatic wait_resp();
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (!bus.resp_valid && n < 20);
    chk("resp_seen", bus.resp_valid, 1);
  endtask

  typedef struct {
    int          port;
    logic [5:0]  op;
    logic [1:0]  w;
    logic [0:63] a;
    logic [0:63] b;
    logic [0:63] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic run_op(input vec_t v, input int idx);
    int g, lat, en;
    bit stable;
    @(negedge clk);
    drive(v.port, 1'b1, v.op, v.w, v.a, v.b);
    wait_grant(g);
    chk($sformatf("v%0d_grant", idx), g, v.port);
    @(posedge clk); #1;
    drive(v.port, 1'b0, v.op, v.w, v.a, v.b);
    @(negedge clk);
    lat = 0; en = 0; stable = 1'b1;
    while (!bus.resp_valid && lat < 20) begin
      if (bus.alu_en) begin
        en++;
        if (bus.reg_a_o !== v.a || bus.reg_b_o !== v.b || bus.alu_op_o !== v.op || bus.width_o !== v.w)
          stable = 1'b0;
      end
      @(negedge clk); lat++;
    end
    chk($sformatf("v%0d_lat", idx),    lat, v.exp_lat);
    chk($sformatf("v%0d_en_cyc", idx), en, v.exp_lat);
    chk($sformatf("v%0d_stable", idx), stable, 1);
    chk($sformatf("v%0d_id", idx),     bus.resp_id, v.port);
    chk($sformatf("v%0d_data", idx),   bus.resp_data, v.exp_data);
    chk($sformatf("v%0d_err", idx),    bus.resp_err, v.exp_err);
    chk($sformatf("v%0d_en_off", idx), bus.alu_en, 0);
    @(negedge clk);
    chk($sformatf("v%0d_rv_drop", idx), bus.resp_valid, 0);
  endtask

  // Both requesters held valid: grants must alternate starting at 'first'.
  task automatic contention(input int n, input int first);
    int g, exp_g;
    exp_g = first;
    drive(0, 1'b1, 6'd2, 2'd3, 64'hFFFF0000FFFF0000, 64'h1234FFFF0000FFFF);
    drive(1, 1'b1, 6'd3, 2'd3, 64'h00FF00FF00FF00FF, 64'h0F0F0F0F0F0F0F0F);
    for (int i = 0; i < n; i++) begin
      wait_grant(g);
      chk($sformatf("cont%0d_grant", i), g, exp_g);
      @(posedge clk); #1;
      if (i == n - 1) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      wait_resp();
      chk($sformatf("cont%0d_id", i), bus.resp_id, exp_g);
      chk($sformatf("cont%0d_data", i), bus.resp_data,
          (exp_g == 0) ? 64'h1234000000000000 : 64'h0FFF0FFF0FFF0FFF);
      exp_g = 1 - exp_g;
    end
    @(negedge clk);
  endtask

  task automatic backpressure();
    int g;
    logic [0:63] d0;
    logic        id0;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    drive(0, 1'b1, 6'd6, 2'd3, 64'd5, 64'd7);
    wait_grant(g);
    chk("bp_grant0", g, 0);
    @(posedge clk); #1;
    drive(0, 1'b1, 6'd6, 2'd3, 64'd10, 64'd20);
    wait_resp();
    d0 = bus.resp_data; id0 = bus.resp_id;
    chk("bp_data", d0, 64'd12);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_rv", i),   bus.resp_valid, 1);
      chk($sformatf("bp_hold%0d_data", i), bus.resp_data, 64'd12);
      chk($sformatf("bp_hold%0d_id", i),   bus.resp_id, 0);
      chk($sformatf("bp_hold%0d_rdy", i),  bus.req0_ready, 0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_next_ready", bus.req0_ready, 1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    wait_resp();
    chk("bp_next_data", bus.resp_data, 64'd30);
    @(negedge clk);
  endtask

  task automatic reset_mid_exec();
    int g;
    @(negedge clk);
    drive(0, 1'b1, 6'd8, 2'd0, 64'h0102030405060708, 64'h0101010101010101);
    wait_grant(g);
    chk("rst_grant0", g, 0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);          // first EXEC cycle
    @(negedge clk);          // second EXEC cycle
    chk("rst_pre_en", bus.alu_en, 1);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("rst_stray%0d", i), bus.resp_valid, 0);
    end
    contention(2, 0);
  endtask

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return 6'($urandom_range(0, 63));
      1:       return $urandom_range(0, 1) ? 6'd8 : 6'd9;
      default: return 6'($urandom_range(1, 11));
    endcase
  endfunction

  // Transaction-level model: one outstanding op, resp lat+1 sampled
  // cycles after accept, fair pointer flips to the other side of each grant.
  task automatic random_phase(input int ncyc);
    bit          busy = 1'b0;
    bit          ptr  = 1'b0;
    int          k = 0, elat = 0, g;
    logic        eid = 1'b0, eerr = 1'b0;
    logic [5:0]  eop = '0;
    logic [1:0]  ew = '0;
    logic [0:63] ea = '0, eb = '0, edata = '0;
    bit          v[2];
    logic [5:0]  op[2];
    logic [1:0]  w[2];
    logic [0:63] a[2], b[2];
    bit          exp_rv;
    for (int p = 0; p < 2; p++) begin
      v[p] = 1'b0; op[p] = '0; w[p] = '0; a[p] = '0; b[p] = '0;
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (busy) k++;
      exp_rv = busy && (k >= elat + 1);
      chk("rnd_rv", bus.resp_valid, exp_rv);
      if (exp_rv) begin
        chk("rnd_id", bus.resp_id, eid);
        chk("rnd_data", bus.resp_data, edata);
        chk("rnd_err", bus.resp_err, eerr);
      end
      chk("rnd_en", bus.alu_en, busy && !eerr && k >= 1 && k <= elat);
      if (bus.alu_en) begin
        chk("rnd_reg_a", bus.reg_a_o, ea);
        chk("rnd_reg_b", bus.reg_b_o, eb);
        chk("rnd_op", bus.alu_op_o, eop);
        chk("rnd_w", bus.width_o, ew);
      end
      for (int p = 0; p < 2; p++) begin
        if (v[p]) begin
          if ($urandom_range(0, 7) == 0) v[p] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          v[p]  = 1'b1;
          op[p] = rand_op();
          w[p]  = 2'($urandom_range(0, 3));
          a[p]  = {$urandom, $urandom};
          b[p]  = {$urandom, $urandom};
        end
        drive(p, v[p], op[p], w[p], a[p], b[p]);
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = (!busy && (v[0] || v[1])) ? ((v[0] && v[1]) ? int'(ptr) : (v[1] ? 1 : 0)) : -1;
      chk("rnd_rdy0", bus.req0_ready, g == 0);
      chk("rnd_rdy1", bus.req1_ready, g == 1);
      if (exp_rv && bus.resp_ready) begin
        busy = 1'b0;
      end else if (g >= 0) begin
        busy  = 1'b1;
        k     = 0;
        eid   = g[0];
        eop   = op[g]; ew = w[g]; ea = a[g]; eb = b[g];
        eerr  = !is_legal(eop);
        elat  = lat_of(eop);
        edata = exp_of(eop, ew, ea, eb);
        ptr   = ~g[0];
        v[g]  = 1'b0;
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.resp_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.resp_ready = 1'b1;
    drive(0, 1'b1, 6'd6, 2'd3, 64'd1, 64'd2);
    drive(1, 1'b1, 6'd6, 2'd3, 64'd3, 64'd4);
    #12;
    chk_all_zero("reset");
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    contention(4, 0);

    vecs[0]  = '{0, 6'd6,  2'd3, 64'd1, 64'd2, 64'd3, 1'b0, ALU_LAT};
    vecs[1]  = '{0, 6'd2,  2'd3, 64'hFFFF0000FFFF0000, 64'h1234FFFF0000FFFF, 64'h1234000000000000, 1'b0, ALU_LAT};
    vecs[2]  = '{1, 6'd3,  2'd3, 64'hFFFF0000FFFF0000, 64'h1234FFFF0000FFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, ALU_LAT};
    vecs[3]  = '{1, 6'd8,  2'd0, 64'h0102030405060708, 64'h0101010101010101,
                 alu_fn(6'd8, 2'd0, 64'h0102030405060708, 64'h0101010101010101), 1'b0, MUL_LAT};
    vecs[4]  = '{0, 6'd9,  2'd1, 64'h00000000DEADBEEF, 64'h0000000000000010, 64'h0000000DEADBEEF0, 1'b0, MUL_LAT};
    vecs[5]  = '{0, 6'd63, 2'd3, 64'h1111, 64'h2222, 64'd0, 1'b1, 0};
    vecs[6]  = '{1, 6'd0,  2'd2, 64'h3333, 64'h4444, 64'd0, 1'b1, 0};
    vecs[7]  = '{0, 6'd12, 2'd1, 64'h5555, 64'h6666, 64'd0, 1'b1, 0};
    vecs[8]  = '{1, 6'd14, 2'd0, 64'h7777, 64'h8888, 64'd0, 1'b1, 0};
    vecs[9]  = '{0, 6'd13, 2'd2, 64'hA5A5A5A5A5A5A5A5, 64'h0123456789ABCDEF,
                 alu_fn(6'd13, 2'd2, 64'hA5A5A5A5A5A5A5A5, 64'h0123456789ABCDEF), 1'b0, ALU_LAT};
    vecs[10] = '{1, 6'd11, 2'd3, 64'h0F0F0F0F0F0F0F0F, 64'hFEDCBA9876543210,
                 alu_fn(6'd11, 2'd3, 64'h0F0F0F0F0F0F0F0F, 64'hFEDCBA9876543210), 1'b0, ALU_LAT};
    vecs[11] = '{0, 6'd1,  2'd0, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000001,
                 alu_fn(6'd1, 2'd0, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000001), 1'b0, ALU_LAT};

    for (int i = 0; i < 12; i++) run_op(vecs[i], i);

    backpressure();
    reset_mid_exec();
    random_phase(600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares the single combinational vector ALU between two requesters: port 0 is the CPU EX stage, port 1 is the NoC-side vector offload.
- Arbitrates round-robin and registers the winning operands onto the ALU inputs.
- Holds the operands for an op-dependent number of cycles, then captures alu_out and returns it with a requester ID over a valid/ready response channel.

Parameters:
DATA_W, 64, operand/result width (bit 0 = MSB, [0:DATA_W-1] ordering)
MUL_LAT, 3, EXEC cycles for VMULEU/VMULOU (>=1)
ALU_LAT, 1, EXEC cycles for all other legal ops (>=1)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle when valid&ready
req0_op  in  6  ALU opcode
req0_width  in  2  lane width (00 b, 01 h, 10 w, 11 d)
req0_a  in  DATA_W  operand A
req0_b  in  DATA_W  operand B
req1_valid, req1_ready, req1_op, req1_width, req1_a, req1_b: same as port 0, for requester 1
alu_en  out  1  drives ALU "alu" enable
alu_op_o  out  6  drives ALU alu_op
width_o  out  2  drives ALU width
reg_a_o  out  DATA_W  drives ALU reg_a_data
reg_b_o  out  DATA_W  drives ALU reg_b_data
alu_out_i  in  DATA_W  ALU result
resp_valid  out  1  result available
resp_ready  in  1  consumer takes result
resp_id  out  1  requester that issued the op
resp_data  out  DATA_W  captured result
resp_err  out  1  op was illegal; resp_data = 0

Behaviour:
- Reset (async, reset_n=0): state IDLE; rr_ptr=0; every output 0, including both req*_ready.
- Legal ops: 000001–001011 and 001101.
  - Multiply class: 001000, 001001.
  - All other values are illegal: 000000, 001100, and >=001110.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant logic is combinational.
  - If exactly one reqN_valid is set, grant N.
  - If both are set, grant rr_ptr.
  - reqN_ready = (state==IDLE) && grant==N. At most one ready is high.
  - On handshake:
    - latch op/width/a/b into the ALU-drive registers;
    - latch id=N;
    - rr_ptr <= ~N;
    - load cnt = MUL_LAT for multiply, else ALU_LAT;
    - illegal op: go straight to RESP with resp_err=1, resp_data=0, and no EXEC.
- EXEC:
  - alu_en=1; drive registers held stable.
  - Decrement cnt each cycle.
  - In the cycle cnt==1: resp_data <= alu_out_i, resp_id <= id, resp_err <= 0, resp_valid <= 1, go RESP.
- RESP:
  - resp_valid=1; resp_data/id/err held stable until resp_ready.
  - On resp_valid&&resp_ready: resp_valid <= 0, go IDLE.
  - No new op is accepted while in RESP (req*_ready=0).
- ALU drive outputs:
  - alu_op_o/width_o/reg_a_o/reg_b_o keep their last latched values outside EXEC.
  - alu_en=0 outside EXEC.
- Timing:
  - Latency from accept edge to resp_valid high = lat cycles (lat = MUL_LAT or ALU_LAT).
  - Illegal op: resp_valid high 1 cycle after accept.
  - Minimum issue interval with resp_ready tied high: lat+2 cycles.
- Requester contract:
  - A requester keeps valid and its payload stable until ready.
  - Deasserting valid without a handshake is legal; no grant is remembered.
- Reset mid-operation: in-flight op discarded, no response produced, rr_ptr returns to 0.
- resp_ready asserted while resp_valid=0: ignored.

Test Plan:
- Single op: req0 VADD (000110), a=1, b=2, width=11, resp_ready=1 -> req0_ready high in accept cycle; alu_en high 1 cycle; resp_valid next cycle with data=64'h3, id=0, err=0.
- Contention: req0 and req1 both valid continuously, ops VAND/VOR -> grants alternate 0,1,0,1 with first grant to 0 after reset; each response carries matching id and data (e.g. VAND FFFF0000FFFF0000 & 1234FFFF0000FFFF = 1234000000000000).
- Multiply latency: req1 VMULEU width=00, a=0102030405060708, b=0101010101010101 -> alu_en high exactly MUL_LAT(3) cycles with reg_a_o/reg_b_o stable; resp_valid on the 4th cycle after accept, id=1.
- Backpressure: resp_ready low 4 cycles with req0 valid pending -> resp_valid/data/id stable, req0_ready stays 0; after resp_ready=1, next op accepted in the following IDLE cycle.
- Illegal op: req0 op=6'b111111 -> alu_en never asserted; resp_valid 1 cycle after accept with err=1, data=0.
- Reset mid-EXEC: assert reset_n=0 during second MUL_LAT cycle -> all outputs 0 immediately; after release no stray resp_valid, and next contention grants req0 first.
